// File: rtl/pipeline_sequencer_if.sv
// Run-control bus between the debug/hazard units and the sequencer.
// Carries the command inputs (i_*) and the pipeline gate outputs (o_*).
interface pipeline_sequencer_if #(
  parameter int NB_CNT = 32
);
  logic              i_start;
  logic              i_step;
  logic              i_halt_req;
  logic              i_halt_id;
  logic              i_stall;
  logic              i_flush_idex;
  logic              o_pc_en;
  logic              o_ifid_en;
  logic              o_idex_flush;
  logic              o_pipe_en;
  logic              o_busy;
  logic              o_done;
  logic [2:0]        o_state;
  logic [NB_CNT-1:0] o_cycle_cnt;

  modport master (
    output i_start, i_step, i_halt_req,
    output i_halt_id, i_stall, i_flush_idex,
    input  o_pc_en, o_ifid_en, o_idex_flush,
    input  o_pipe_en, o_busy, o_done,
    input  o_state, o_cycle_cnt
  );

  modport slave (
    input  i_start, i_step, i_halt_req,
    input  i_halt_id, i_stall, i_flush_idex,
    output o_pc_en, o_ifid_en, o_idex_flush,
    output o_pipe_en, o_busy, o_done,
    output o_state, o_cycle_cnt
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Run-control sequencer: gates PC and pipeline registers for
// start/step/pause, merges hazard stall/flush, drains on HALT.
// Ports: i_clk, i_rst (async, active-high), bus (slave modport):
//   commands i_start/i_step/i_halt_req/i_halt_id/i_stall/i_flush_idex,
//   gates o_pc_en/o_ifid_en/o_idex_flush/o_pipe_en,
//   status o_busy/o_done/o_state/o_cycle_cnt.
module pipeline_sequencer #(
  parameter int NB_CNT       = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  pipeline_sequencer_if.slave  bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_STEP  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] DRN = 4'(DRAIN_CYCLES);

  logic [2:0]        r_state;
  logic [3:0]        r_drain;
  logic [NB_CNT-1:0] r_cnt;

  logic [2:0] w_next;
  logic       w_load;
  logic       w_pc_en;
  logic       w_ifid_en;
  logic       w_flush;
  logic       w_pipe_en;

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_pc_en   = 1'b0;
    w_ifid_en = 1'b0;
    w_flush   = 1'b0;
    w_pipe_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start)
          w_next = S_RUN;
        else if (bus.i_step)
          w_next = S_STEP;
      end
      S_RUN, S_STEP: begin
        priority case (1'b1)
          bus.i_halt_req: begin
            w_next = S_IDLE;
          end
          // HALT moves into EX; fetch freezes.
          bus.i_halt_id: begin
            w_pipe_en = 1'b1;
            w_load    = 1'b1;
            w_next    = S_DRAIN;
          end
          default: begin
            w_pipe_en = 1'b1;
            w_pc_en   = ~bus.i_stall;
            w_ifid_en = ~bus.i_stall;
            w_flush   = bus.i_flush_idex;
            w_next    = (r_state == S_RUN) ?
                        S_RUN : S_IDLE;
          end
        endcase
      end
      // Bubble ID/EX so the frozen HALT is not re-issued.
      S_DRAIN: begin
        w_pipe_en = 1'b1;
        w_flush   = 1'b1;
        if (r_drain == 4'd1)
          w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_DONE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_drain <= 4'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_load)
        r_drain <= DRN;
      else if (r_state == S_DRAIN)
        r_drain <= r_drain - 4'd1;
      if (w_pipe_en && (r_cnt != '1))
        r_cnt <= r_cnt + NB_CNT'(1);
    end
  end

  assign bus.o_pc_en      = w_pc_en;
  assign bus.o_ifid_en    = w_ifid_en;
  assign bus.o_idex_flush = w_flush;
  assign bus.o_pipe_en    = w_pipe_en;
  assign bus.o_busy       = (r_state == S_RUN)
                          | (r_state == S_STEP)
                          | (r_state == S_DRAIN);
  assign bus.o_done       = (r_state == S_DONE);
  assign bus.o_state      = r_state;
  assign bus.o_cycle_cnt  = r_cnt;
endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Run-control sequencer for the 5-stage MIPS pipeline. It gates the PC and the pipeline registers for the debug unit's start, single-step and pause commands. It merges those gates with the hazard unit's stall and ID/EX flush requests. It drains the pipeline cleanly when a HALT instruction is decoded.

## Interface
Parameters:
- NB_CNT, 32, width of the advanced-cycle counter
- DRAIN_CYCLES, 3, pipeline cycles spent in DRAIN after HALT leaves ID (range 1..15)

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge
- i_rst  in  1  reset; asynchronous, active-high
- i_start  in  1  single-cycle pulse from the debug unit: begin continuous run
- i_step  in  1  single-cycle pulse from the debug unit: advance exactly one cycle
- i_halt_req  in  1  pause request from the debug unit (resumable)
- i_halt_id  in  1  HALT opcode decoded in the ID stage
- i_stall  in  1  hazard-unit stall (load-use or branch operand)
- i_flush_idex  in  1  hazard-unit ID/EX bubble request
- o_pc_en  out  1  PC write enable
- o_ifid_en  out  1  IF/ID write enable
- o_idex_flush  out  1  load a NOP into ID/EX; has priority over the write enable
- o_pipe_en  out  1  write enable for ID/EX, EX/MEM and MEM/WB
- o_busy  out  1  high in RUN, STEP or DRAIN
- o_done  out  1  high in DONE
- o_state  out  3  encoded state: IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4
- o_cycle_cnt  out  NB_CNT  number of cycles with o_pipe_en=1; saturates at all ones

## Operation
- The state register, drain counter (4 bits) and cycle counter are sequential. All enable outputs are combinational from the current state and the current inputs.
- IDLE: all enables and the flush are 0.
  - i_start goes to RUN.
  - Otherwise i_step goes to STEP.
  - If both are high, i_start wins.
- RUN and STEP share the same "advance" decode, with priority i_halt_req > i_halt_id > normal:
  - i_halt_req: all enables 0 this cycle, next state IDLE. The pipeline does not move. Resume with i_start or i_step.
  - i_halt_id: o_pc_en=o_ifid_en=0, o_pipe_en=1, o_idex_flush=0, so HALT moves into EX and fetch freezes. Drain counter loads DRAIN_CYCLES. Next state DRAIN.
  - normal: o_pipe_en=1, o_pc_en=o_ifid_en=~i_stall, o_idex_flush=i_flush_idex. Next state: RUN stays RUN; STEP returns to IDLE.
- i_halt_id outranks i_stall. A stall coincident with HALT is discarded.
- DRAIN:
  - Outputs: o_pipe_en=1, o_pc_en=o_ifid_en=0, o_idex_flush=1 (the frozen HALT in IF/ID is not re-issued).
  - The counter decrements each cycle. When it equals 1, the next state is DONE.
  - i_halt_req, i_start, i_step, i_stall and i_flush_idex are ignored.
- DONE: all enables 0, o_done=1. Leaves only on i_rst; i_start and i_step are ignored.
- Cycle counter: +1 on each edge where o_pipe_en=1. It holds at 2^NB_CNT-1 and does not wrap.
- o_busy and o_done are decoded from the state register only (glitch-free).

## Timing
- Reset (async, immediate) sets: state IDLE, drain counter 0, o_cycle_cnt 0.
- Reset values of the outputs: o_pc_en=o_ifid_en=o_pipe_en=o_idex_flush=0, o_busy=0, o_done=0, o_state=0.
- Command latency: a start or step pulse at edge N produces enables in cycle N+1, the first cycle in RUN or STEP.
- STEP lasts exactly one cycle. Extra i_step pulses while in STEP are ignored.
- Halt latency: i_halt_id in cycle N gives one entry cycle in N, DRAIN for cycles N+1..N+DRAIN_CYCLES, and DONE from N+DRAIN_CYCLES+1.
- Total o_pipe_en=1 cycles from HALT decode to DONE: DRAIN_CYCLES+1.
- Reset asserted mid-DRAIN or mid-RUN aborts immediately to IDLE. No partial drain resumes after reset release.
- i_halt_req takes effect combinationally in the same cycle; no pipeline advance occurs in that cycle.

## Test plan
- Reset, then i_start pulse, with i_stall=0 for 10 cycles: o_state 0→1, o_pipe_en=o_pc_en=1 each cycle, o_cycle_cnt=10.
- In RUN, i_stall=1 for 1 cycle with i_flush_idex=1: that cycle o_pc_en=o_ifid_en=0, o_pipe_en=1, o_idex_flush=1; the cycle count still increments.
- From IDLE, 3 i_step pulses spaced 4 cycles apart: exactly 3 cycles with o_pipe_en=1, state returning to 0 after each, o_cycle_cnt=3.
- In RUN, i_halt_req for 1 cycle, then i_start: zero enables in the request cycle, IDLE, then RUN resumes; cycle count excludes the paused cycle.
- In RUN with DRAIN_CYCLES=3, i_halt_id at cycle N (i_stall=1 too): entry cycle at N, DRAIN for N+1..N+3 with o_idex_flush=1, o_done=1 from N+4; a later i_start has no effect.
- i_rst asserted mid-DRAIN: outputs immediately 0 and o_state=0, asynchronously before the next edge; DONE is never reached.
